// File: rtl/sdram_pkg.sv
// Shared types and helpers for the SDRAM Avalon bridge: FSM state encoding,
// lane geometry helpers and byte-enable generation.
package sdram_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WREQ  = 2'd1,
    RREQ  = 2'd2,
    RWAIT = 2'd3
  } state_e;

  // Widest byte-enable vector the helper can produce (512-bit controller)
  localparam int unsigned BE_MAX_W = 64;

  function automatic int unsigned lanes_of(input int unsigned user_dw, input int unsigned avl_dw);
    return avl_dw / user_dw;
  endfunction

  function automatic int unsigned lane_w_of(input int unsigned user_dw, input int unsigned avl_dw);
    return $clog2(avl_dw / user_dw);
  endfunction

  // lane_bytes ones placed at the byte offset of the selected lane
  function automatic logic [BE_MAX_W-1:0] lane_be(input int unsigned lane,
                                                  input int unsigned lane_bytes);
    logic [BE_MAX_W-1:0] ones;
    ones = '0;
    for (int unsigned i = 0; i < BE_MAX_W; i++) begin
      if (i < lane_bytes) ones[i] = 1'b1;
    end
    return ones << (lane * lane_bytes);
  endfunction

endpackage

// File: rtl/sdram_lane_mux.sv
// Combinational lane steering: byte enables and write-data replication for the
// write lane, and extraction of the read lane from a controller word.
module sdram_lane_mux
  import sdram_pkg::*;
#(
  parameter int unsigned USER_DW = 8,
  parameter int unsigned AVL_DW  = 32,
  localparam int unsigned LANES  = lanes_of(USER_DW, AVL_DW),
  localparam int unsigned LANE_W = lane_w_of(USER_DW, AVL_DW),
  localparam int unsigned BE_W   = AVL_DW / 8
) (
  input  logic [LANE_W-1:0]  wr_lane_i,
  input  logic [USER_DW-1:0] wdata_i,
  input  logic [LANE_W-1:0]  rd_lane_i,
  input  logic [AVL_DW-1:0]  rdata_i,
  output logic [BE_W-1:0]    be_o,
  output logic [AVL_DW-1:0]  wdata_rep_o,
  output logic [USER_DW-1:0] rdata_lane_o
);

  assign be_o        = BE_W'(lane_be(32'(wr_lane_i), USER_DW / 8));
  assign wdata_rep_o = {LANES{wdata_i}};

  always_comb begin
    rdata_lane_o = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (rd_lane_i == LANE_W'(i)) rdata_lane_o = rdata_i[i*USER_DW +: USER_DW];
    end
  end

endmodule

// File: rtl/sdram_avl_bridge.sv
// Narrow collector port to wide Avalon-MM SDRAM controller bridge with read timeout.
// Optional one-word read cache is built when SDRAM_BRIDGE_READ_CACHE_EN is defined.
module sdram_avl_bridge
  import sdram_pkg::*;
#(
  parameter int unsigned ADDR_W    = 21,
  parameter int unsigned USER_DW   = 8,
  parameter int unsigned AVL_DW    = 32,
  parameter int unsigned TO_CYCLES = 255,
  localparam int unsigned LANE_W   = lane_w_of(USER_DW, AVL_DW),
  localparam int unsigned WORD_W   = ADDR_W - LANE_W,
  localparam int unsigned BE_W     = AVL_DW / 8
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic [USER_DW-1:0]  i_D,
  input  logic                i_re,
  input  logic                i_we,
  output logic [USER_DW-1:0]  o_D,
  output logic                o_valid,
  output logic                o_busy,
  output logic                o_err,
  output logic [WORD_W-1:0]   o_avl_addr,
  output logic [BE_W-1:0]     o_avl_be,
  output logic [AVL_DW-1:0]   o_avl_wdata,
  output logic                o_avl_read_req,
  output logic                o_avl_write_req,
  output logic                o_avl_burstbegin,
  output logic                o_avl_size,
  input  logic                i_avl_ready,
  input  logic [AVL_DW-1:0]   i_avl_rdata,
  input  logic                i_avl_rdata_valid
);

  localparam int unsigned CNT_W = $clog2(TO_CYCLES + 1);

  state_e               state_q, state_d;
  logic [WORD_W-1:0]    word_q, word_d;
  logic [LANE_W-1:0]    lane_q, lane_d;
  logic [USER_DW-1:0]   rd_q, rd_d;
  logic                 valid_q, valid_d;
  logic                 err_q, err_d;
  logic                 busy_q, busy_d;
  logic                 rreq_q, rreq_d;
  logic                 wreq_q, wreq_d;
  logic                 bb_q, bb_d;
  logic [BE_W-1:0]      be_q, be_d;
  logic [AVL_DW-1:0]    wdata_q, wdata_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic [WORD_W-1:0]    addr_word_c;
  logic [LANE_W-1:0]    addr_lane_c;
  logic [BE_W-1:0]      be_c;
  logic [AVL_DW-1:0]    wrep_c;
  logic [USER_DW-1:0]   rlane_c;
  logic                 to_c;
  logic                 hit_c;
  logic [USER_DW-1:0]   hit_data_c;

  assign addr_word_c = i_addr[ADDR_W-1:LANE_W];
  assign addr_lane_c = i_addr[LANE_W-1:0];
  assign to_c        = (cnt_q == CNT_W'(TO_CYCLES - 1));

  sdram_lane_mux #(
    .USER_DW (USER_DW),
    .AVL_DW  (AVL_DW)
  ) u_lane_mux (
    .wr_lane_i    (addr_lane_c),
    .wdata_i      (i_D),
    .rd_lane_i    (lane_q),
    .rdata_i      (i_avl_rdata),
    .be_o         (be_c),
    .wdata_rep_o  (wrep_c),
    .rdata_lane_o (rlane_c)
  );

`ifdef SDRAM_BRIDGE_READ_CACHE_EN
  localparam int unsigned LANES = lanes_of(USER_DW, AVL_DW);

  logic                 cvalid_q, cvalid_d;
  logic [WORD_W-1:0]    ctag_q, ctag_d;
  logic [AVL_DW-1:0]    cdata_q, cdata_d;

  assign hit_c = cvalid_q && (ctag_q == addr_word_c);

  always_comb begin
    hit_data_c = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (addr_lane_c == LANE_W'(i)) hit_data_c = cdata_q[i*USER_DW +: USER_DW];
    end
  end

  // Fill on returned data, drop on timeout, write-through on an accepted write to the cached word
  always_comb begin
    cvalid_d = cvalid_q;
    ctag_d   = ctag_q;
    cdata_d  = cdata_q;
    if (state_q == RWAIT && i_avl_rdata_valid) begin
      cvalid_d = 1'b1;
      ctag_d   = word_q;
      cdata_d  = i_avl_rdata;
    end else if (state_q == RWAIT && to_c) begin
      cvalid_d = 1'b0;
    end else if (state_q == IDLE && !i_re && i_we && hit_c) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (addr_lane_c == LANE_W'(i)) cdata_d[i*USER_DW +: USER_DW] = i_D;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cvalid_q <= 1'b0;
    end else begin
      cvalid_q <= cvalid_d;
    end
  end

  always_ff @(posedge i_clk) begin
    ctag_q  <= ctag_d;
    cdata_q <= cdata_d;
  end
`else
  assign hit_c      = 1'b0;
  assign hit_data_c = '0;
`endif

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    lane_d  = lane_q;
    rd_d    = rd_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    busy_d  = busy_q;
    rreq_d  = rreq_q;
    wreq_d  = wreq_q;
    bb_d    = 1'b0;
    be_d    = be_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      IDLE: begin
        busy_d  = 1'b0;
        rreq_d  = 1'b0;
        wreq_d  = 1'b0;
        be_d    = '0;
        wdata_d = '0;
        if (i_re && hit_c) begin
          rd_d    = hit_data_c;
          valid_d = 1'b1;
        end else if (i_re) begin
          state_d = RREQ;
          word_d  = addr_word_c;
          lane_d  = addr_lane_c;
          busy_d  = 1'b1;
          rreq_d  = 1'b1;
          bb_d    = 1'b1;
          be_d    = '1;
        end else if (i_we) begin
          state_d = WREQ;
          word_d  = addr_word_c;
          lane_d  = addr_lane_c;
          busy_d  = 1'b1;
          wreq_d  = 1'b1;
          bb_d    = 1'b1;
          be_d    = be_c;
          wdata_d = wrep_c;
        end
      end
      WREQ: begin
        if (i_avl_ready) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          wreq_d  = 1'b0;
          be_d    = '0;
          wdata_d = '0;
        end
      end
      RREQ: begin
        if (i_avl_ready) begin
          state_d = RWAIT;
          rreq_d  = 1'b0;
          be_d    = '0;
          cnt_d   = '0;
        end
      end
      RWAIT: begin
        // Data arriving on the final allowed cycle still beats the timeout
        if (i_avl_rdata_valid) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          rd_d    = rlane_c;
          valid_d = 1'b1;
        end else if (to_c) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      word_q  <= '0;
      lane_q  <= '0;
      rd_q    <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      rreq_q  <= 1'b0;
      wreq_q  <= 1'b0;
      bb_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      lane_q  <= lane_d;
      rd_q    <= rd_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      rreq_q  <= rreq_d;
      wreq_q  <= wreq_d;
      bb_q    <= bb_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_D              = rd_q;
  assign o_valid          = valid_q;
  assign o_busy           = busy_q;
  assign o_err            = err_q;
  assign o_avl_addr       = word_q;
  assign o_avl_be         = be_q;
  assign o_avl_wdata      = wdata_q;
  assign o_avl_read_req   = rreq_q;
  assign o_avl_write_req  = wreq_q;
  assign o_avl_burstbegin = bb_q;
  assign o_avl_size       = 1'b1;

endmodule

// File: tb/tb_sdram_avl_bridge.sv
// Randomized bench for sdram_avl_bridge: a transaction-level controller/memory model
// produces the expected outputs, compared against the DUT every cycle.
module tb_sdram_avl_bridge;

  localparam int unsigned ADDR_W = 21;
  localparam int unsigned TO     = 16;
`ifdef SDRAM_BRIDGE_READ_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              i_rst, i_re, i_we, i_avl_ready, i_avl_rdata_valid;
  logic [ADDR_W-1:0] i_addr;
  logic [7:0]        i_D;
  logic [31:0]       i_avl_rdata;
  logic [7:0]        o_D;
  logic              o_valid, o_busy, o_err;
  logic [18:0]       o_avl_addr;
  logic [3:0]        o_avl_be;
  logic [31:0]       o_avl_wdata;
  logic              o_avl_read_req, o_avl_write_req, o_avl_burstbegin, o_avl_size;

  always #5 clk = ~clk;

  sdram_avl_bridge #(.ADDR_W(21), .USER_DW(8), .AVL_DW(32), .TO_CYCLES(TO)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_addr(i_addr), .i_D(i_D), .i_re(i_re), .i_we(i_we),
    .o_D(o_D), .o_valid(o_valid), .o_busy(o_busy), .o_err(o_err),
    .o_avl_addr(o_avl_addr), .o_avl_be(o_avl_be), .o_avl_wdata(o_avl_wdata),
    .o_avl_read_req(o_avl_read_req), .o_avl_write_req(o_avl_write_req),
    .o_avl_burstbegin(o_avl_burstbegin), .o_avl_size(o_avl_size),
    .i_avl_ready(i_avl_ready), .i_avl_rdata(i_avl_rdata), .i_avl_rdata_valid(i_avl_rdata_valid)
  );

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // Expected outputs for the current cycle
  logic [7:0]  ex_D;
  logic        ex_valid, ex_err, ex_busy, ex_rreq, ex_wreq, ex_bb, ex_full;
  logic [18:0] ex_addr;
  logic [3:0]  ex_be;
  logic [31:0] ex_wdata;

  // Controller memory and cache bookkeeping
  logic [31:0] mem [int unsigned];
  bit          c_valid = 1'b0;
  int unsigned c_tag   = 0;

  int          wr_cnt = 0, rd_cnt = 0;
  logic [18:0] cap_addr;
  logic [3:0]  cap_be;
  logic [31:0] cap_wdata;

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("o_valid", 64'(o_valid), 64'(ex_valid));
      cmp("o_err", 64'(o_err), 64'(ex_err));
      cmp("o_busy", 64'(o_busy), 64'(ex_busy));
      cmp("read_req", 64'(o_avl_read_req), 64'(ex_rreq));
      cmp("write_req", 64'(o_avl_write_req), 64'(ex_wreq));
      cmp("burstbegin", 64'(o_avl_burstbegin), 64'(ex_bb));
      cmp("size", 64'(o_avl_size), 64'd1);
      cmp("avl_addr", 64'(o_avl_addr), 64'(ex_addr));
      cmp("o_D", 64'(o_D), 64'(ex_D));
      if (ex_full || ex_rreq || ex_wreq) cmp("be", 64'(o_avl_be), 64'(ex_be));
      if (ex_full || ex_wreq) cmp("wdata", 64'(o_avl_wdata), 64'(ex_wdata));
    end
    if (o_avl_write_req && o_avl_burstbegin) begin
      wr_cnt++;
      cap_addr  = o_avl_addr;
      cap_be    = o_avl_be;
      cap_wdata = o_avl_wdata;
    end
    if (o_avl_read_req && o_avl_burstbegin) rd_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ex_idle();
    ex_valid = 1'b0; ex_err = 1'b0; ex_busy = 1'b0;
    ex_rreq = 1'b0; ex_wreq = 1'b0; ex_bb = 1'b0;
    ex_be = '0; ex_wdata = '0;
  endtask

  task automatic quiet();
    i_re = 1'b0; i_we = 1'b0; i_avl_ready = 1'b0; i_avl_rdata_valid = 1'b0;
  endtask

  // Requests presented while busy must be ignored
  task automatic junk_req();
    i_re = 1'($urandom); i_we = 1'($urandom);
    i_addr = ADDR_W'($urandom); i_D = 8'($urandom);
  endtask

  function automatic logic [7:0] lane_of(input logic [31:0] wd, input int lane);
    return wd[lane*8 +: 8];
  endfunction

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [7:0] d, input int rdly);
    int unsigned w;
    int lane;
    logic [31:0] mw;
    w = int'(a >> 2); lane = int'(a[1:0]);
    quiet(); i_we = 1'b1; i_addr = a; i_D = d;
    tick();
    junk_req();
    ex_busy = 1'b1; ex_wreq = 1'b1; ex_bb = 1'b1; ex_addr = 19'(w);
    ex_be = 4'(1 << lane); ex_wdata = {4{d}};
    for (int k = 0; k <= rdly; k++) begin
      i_avl_ready = (k == rdly);
      if (k > 0) ex_bb = 1'b0;
      tick();
    end
    quiet(); ex_idle();
    mw = mem.exists(w) ? mem[w] : $urandom;
    mw[lane*8 +: 8] = d;
    mem[w] = mw;
  endtask

  // vdly < 0 means the controller never returns data
  task automatic do_read(input logic [ADDR_W-1:0] a, input int rdly, input int vdly, input bit also_we);
    int unsigned w;
    int lane;
    bit hit;
    w = int'(a >> 2); lane = int'(a[1:0]);
    if (!mem.exists(w)) mem[w] = $urandom;
    hit = CACHE && c_valid && (c_tag == w);
    quiet(); i_re = 1'b1; i_we = also_we; i_addr = a; i_D = 8'($urandom);
    tick();
    if (hit) begin
      quiet();
      ex_valid = 1'b1; ex_D = lane_of(mem[w], lane);
      tick();
      ex_valid = 1'b0;
      return;
    end
    junk_req();
    ex_busy = 1'b1; ex_rreq = 1'b1; ex_bb = 1'b1; ex_be = 4'hF; ex_addr = 19'(w);
    for (int k = 0; k <= rdly; k++) begin
      i_avl_ready = (k == rdly);
      i_avl_rdata_valid = 1'($urandom);
      i_avl_rdata = $urandom;
      if (k > 0) ex_bb = 1'b0;
      tick();
    end
    i_avl_ready = 1'b0; ex_rreq = 1'b0; ex_bb = 1'b0;
    if (vdly >= 0) begin
      for (int k = 0; k <= vdly; k++) begin
        i_avl_rdata_valid = (k == vdly);
        i_avl_rdata = (k == vdly) ? mem[w] : $urandom;
        tick();
      end
      quiet(); ex_busy = 1'b0; ex_valid = 1'b1; ex_D = lane_of(mem[w], lane);
      c_valid = 1'b1; c_tag = w;
      tick();
      ex_valid = 1'b0;
    end else begin
      for (int k = 0; k < int'(TO); k++) begin
        i_avl_rdata_valid = 1'b0;
        tick();
      end
      quiet(); ex_busy = 1'b0; ex_err = 1'b1;
      c_valid = 1'b0;
      i_avl_rdata_valid = 1'b1; i_avl_rdata = $urandom;
      tick();
      ex_err = 1'b0;
      tick();
      i_avl_rdata_valid = 1'b0;
    end
  endtask

  task automatic do_reset_mid(input logic [ADDR_W-1:0] a_in);
    logic [ADDR_W-1:0] a;
    int unsigned w;
    a = a_in;
    if (CACHE && c_valid && (c_tag == int'(a >> 2))) a = a ^ ADDR_W'(4);
    w = int'(a >> 2);
    quiet(); i_re = 1'b1; i_addr = a;
    tick();
    junk_req();
    ex_busy = 1'b1; ex_rreq = 1'b1; ex_bb = 1'b1; ex_be = 4'hF; ex_addr = 19'(w);
    i_avl_ready = 1'b1;
    tick();
    i_avl_ready = 1'b0; ex_rreq = 1'b0; ex_bb = 1'b0;
    tick();
    tick();
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0; quiet();
    ex_idle(); ex_D = '0; ex_addr = '0; ex_full = 1'b1; c_valid = 1'b0;
    i_avl_rdata_valid = 1'b1; i_avl_rdata = $urandom;
    tick();
    i_avl_rdata_valid = 1'b0;
    tick();
    ex_full = 1'b0;
  endtask

  task automatic gap(input int n);
    for (int k = 0; k < n; k++) begin
      quiet();
      i_avl_ready = 1'($urandom); i_avl_rdata_valid = 1'($urandom); i_avl_rdata = $urandom;
      tick();
    end
    quiet();
  endtask

  initial begin
    int rd0, wr0, op;
    logic [ADDR_W-1:0] ra;
    i_rst = 1'b1; quiet(); i_addr = '0; i_D = '0; i_avl_rdata = '0;
    ex_idle(); ex_D = '0; ex_addr = '0; ex_full = 1'b1;
    tick();
    tick();
    chk_en = 1'b1;
    tick();
    i_rst = 1'b0;
    tick();
    ex_full = 1'b0;

    do_write(21'h000005, 8'hA5, 0);
    cmp("t1_addr", 64'(cap_addr), 64'h1);
    cmp("t1_be", 64'(cap_be), 64'b0010);
    cmp("t1_wdata", 64'(cap_wdata), 64'hA5A5A5A5);
    cmp("t1_wr_count", 64'(wr_cnt), 64'd1);
    mem[1] = 32'h11223344;

    do_read(21'h000006, 0, 3, 1'b0);
    cmp("t2_oD", 64'(o_D), 64'h22);

    rd0 = rd_cnt;
    do_read(21'h000007, 0, 2, 1'b0);
    cmp("t6_oD", 64'(o_D), 64'h11);
    cmp("t6_rd_issued", 64'(rd_cnt - rd0), CACHE ? 64'd0 : 64'd1);
    do_write(21'h000007, 8'h5A, 1);
    do_read(21'h000007, 1, 1, 1'b0);
    cmp("t6_oD_after_wr", 64'(o_D), 64'h5A);

    do_write(21'h000009, 8'h3C, 5);

    wr0 = wr_cnt;
    do_read(21'h000004, 0, 1, 1'b1);
    cmp("t4_no_write", 64'(wr_cnt), 64'(wr0));
    cmp("t4_oD", 64'(o_D), 64'h44);

    do_read(21'h000008, 1, -1, 1'b0);
    cmp("t5_oD_kept", 64'(o_D), 64'h44);
    do_read(21'h00000C, 0, int'(TO) - 1, 1'b0);
    do_reset_mid(21'h000010);

    for (int n = 0; n < 400; n++) begin
      gap($urandom_range(0, 2));
      op = $urandom_range(0, 99);
      ra = ADDR_W'($urandom_range(0, 31));
      if (op < 40)      do_write(ra, 8'($urandom), $urandom_range(0, 3));
      else if (op < 80) do_read(ra, $urandom_range(0, 3), $urandom_range(0, TO - 1), 1'b0);
      else if (op < 88) do_read(ra, $urandom_range(0, 3), $urandom_range(0, TO - 1), 1'b1);
      else if (op < 96) do_read(ra, $urandom_range(0, 3), -1, 1'b0);
      else              do_reset_mid(ra);
    end

    gap(3);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
